matrix_scan_controller: RTL and testbench

- Sequences the 3-column LED matrix scan for the irrigation status display. The matrix is 5 columns wide, but images are mirrored, so only 3 physical column drives exist.
- Generates the one-hot column strobe and the matching 7-bit row pattern for the active glyph.
- Inserts anti-ghosting blanking between column slots.
- Accepts glyph-change requests from the system FSM through a req/ack handshake, applied only at frame boundaries.
- Sits between the irrigation status logic and the matrix pins. It replaces the free-running column ring counter as the column-timing source.

---
 rtl/matrix_pkg.sv | 45 ++++
 rtl/matrix_scan_controller_if.sv | 10 +
 rtl/matrix_glyph_rom.sv | 15 +
 rtl/matrix_scan_controller.sv | 139 +++++++++++++
 tb/tb_matrix_scan_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix scan controller:
// scan states, glyph indices, column strobes and the glyph bitmap table.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [1:0] GLYPH_IDLE      = 2'd0;
    localparam logic [1:0] GLYPH_WATERING  = 2'd1;
    localparam logic [1:0] GLYPH_LOW_WATER = 2'd2;
    localparam logic [1:0] GLYPH_ERROR     = 2'd3;

    // Mirrored matrix: index 0 drives the outer pair, 2 the centre column.
    localparam logic [2:0] COL_OFF    = 3'b000;
    localparam logic [2:0] COL_OUTER  = 3'b100;
    localparam logic [2:0] COL_INNER  = 3'b010;
    localparam logic [2:0] COL_CENTRE = 3'b001;

    // Glyph bitmap: one 7-bit row pattern per (glyph, column index).
    // Column index 3 does not exist on the panel and reads as dark.
    function automatic logic [6:0] glyph_row(input logic [1:0] glyph,
                                             input logic [1:0] index);
        logic [6:0] bits;
        case ({glyph, index})
            4'b00_00: bits = 7'h08;
            4'b00_01: bits = 7'h14;
            4'b00_10: bits = 7'h22;
            4'b01_00: bits = 7'h1C;
            4'b01_01: bits = 7'h3E;
            4'b01_10: bits = 7'h7F;
            4'b10_00: bits = 7'h40;
            4'b10_01: bits = 7'h60;
            4'b10_10: bits = 7'h70;
            4'b11_00: bits = 7'h41;
            4'b11_01: bits = 7'h22;
            4'b11_10: bits = 7'h1C;
            default:  bits = 7'h00;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/matrix_scan_controller_if.sv
// Glyph-change request/acknowledge handshake between the system FSM
// (master) and the matrix scan controller (slave).
interface matrix_scan_controller_if;
    logic [1:0] img_sel;
    logic       img_req;
    logic       img_ack;

    modport master (output img_sel, output img_req, input  img_ack);
    modport slave  (input  img_sel, input  img_req, output img_ack);
endinterface

// File: rtl/matrix_glyph_rom.sv
// Combinational glyph table lookup: (glyph, column index) -> row pattern.
module matrix_glyph_rom
    import matrix_pkg::*;
(
    input  logic [1:0] glyph,
    input  logic [1:0] index,
    output logic [6:0] row
);

    // Table lookup; index 3 yields an all-dark row.
    always_comb begin
        row = glyph_row(glyph, index);
    end

endmodule

// File: rtl/matrix_scan_controller.sv
// 3-column LED matrix scan sequencer with per-slot blanking and
// frame-synchronous glyph switching.
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int DIV_WIDTH    = 16,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    matrix_scan_controller_if.slave  img_bus,
    output logic [2:0]               col,
    output logic [6:0]               row,
    output logic                     frame_tick
);

    if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= SCAN_DIV) ||
        (longint'(SCAN_DIV) > ((longint'(1) << DIV_WIDTH) - longint'(1)))) begin : g_bad_params
        $error("matrix_scan_controller: need 1 <= BLANK_CYCLES < SCAN_DIV <= 2^DIV_WIDTH-1");
    end

    localparam logic [DIV_WIDTH-1:0] SLOT_LAST  = DIV_WIDTH'(SCAN_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);

    scan_state_e          state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic [1:0]           glyph_q, glyph_d;
    logic [2:0]           col_q, col_d;
    logic [6:0]           row_q, row_d;
    logic                 ack_q, ack_d;
    logic                 tick_q, tick_d;
    logic                 boundary_s;
    logic                 take_s;
    logic [6:0]           rom_row_s;

    // Outputs are looked up from the next state so they line up with state_q.
    matrix_glyph_rom u_rom (
        .glyph (glyph_d),
        .index (idx_d),
        .row   (rom_row_s)
    );

    // Next-state, handshake and output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        col_d   = COL_OFF;
        row_d   = 7'd0;

        boundary_s = (state_q == DRIVE) && (idx_q == 2'd2) && (presc_q == SLOT_LAST);
        // The ack cycle itself never counts as a fresh request.
        take_s     = img_bus.img_req && !ack_q && (boundary_s || (state_q == IDLE));
        glyph_d    = take_s ? img_bus.img_sel : glyph_q;
        ack_d      = take_s;
        tick_d     = boundary_s && enable;

        if (!enable) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = 2'd0;
                    presc_d = '0;
                end
                BLANK: begin
                    presc_d = presc_q + 1'b1;
                    if (presc_q == BLANK_LAST) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = BLANK;
                    end
                end
                DRIVE: begin
                    if (presc_q == SLOT_LAST) begin
                        state_d = BLANK;
                        presc_d = '0;
                        idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    presc_d = '0;
                end
            endcase
        end

        if (state_d == DRIVE) begin
            case (idx_d)
                2'd0:    col_d = COL_OUTER;
                2'd1:    col_d = COL_INNER;
                2'd2:    col_d = COL_CENTRE;
                default: col_d = COL_OFF;
            endcase
            row_d = rom_row_s;
        end else begin
            col_d = COL_OFF;
            row_d = 7'd0;
        end
    end

    // State, counters, active glyph and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            presc_q <= '0;
            glyph_q <= GLYPH_IDLE;
            col_q   <= COL_OFF;
            row_q   <= 7'd0;
            ack_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            glyph_q <= glyph_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ack_q   <= ack_d;
            tick_q  <= tick_d;
        end
    end

    assign col             = col_q;
    assign row             = row_q;
    assign frame_tick      = tick_q;
    assign img_bus.img_ack = ack_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Scoreboard bench for matrix_scan_controller with SCAN_DIV=8, BLANK_CYCLES=2.
// Stimulus pushes expected outputs (tagged with a cycle number) and expected
// ack cycles; a negedge monitor pops and compares them.
module tb_matrix_scan_controller;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [2:0] col;
    logic [6:0] row;
    logic       frame_tick;

    matrix_scan_controller_if img_if ();

    matrix_scan_controller #(
        .DIV_WIDTH    (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .img_bus    (img_if),
        .col        (col),
        .row        (row),
        .frame_tick (frame_tick)
    );

    // Hand-written glyph bitmaps [glyph][column index]
    localparam logic [6:0] G0C0 = 7'h08, G0C1 = 7'h14, G0C2 = 7'h22;
    localparam logic [6:0] G1C0 = 7'h1C, G1C1 = 7'h3E;
    localparam logic [6:0] G2C0 = 7'h40;
    localparam logic [6:0] G3C0 = 7'h41;

    typedef struct {
        int         cyc;
        string      name;
        logic [2:0] col;
        logic [6:0] row;
        logic       tick;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    int   ack_exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    bit   drained = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_out(input string nm, input logic [2:0] c, input logic [6:0] r,
                              input logic t, input logic a);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.col = c; e.row = r; e.tick = t; e.ack = a;
        exp_q.push_back(e);
    endtask

    // Monitor: compares queued expectations and every ack pulse.
    always @(negedge clock) begin
        exp_t e;
        int   a;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc || col !== e.col || row !== e.row ||
                frame_tick !== e.tick || img_if.img_ack !== e.ack) begin
                errors++;
                $display("FAIL %s cyc=%0d: got col=%b row=%h tick=%b ack=%b, want col=%b row=%h tick=%b ack=%b",
                         e.name, cyc, col, row, frame_tick, img_if.img_ack, e.col, e.row, e.tick, e.ack);
            end
        end
        if (img_if.img_ack === 1'b1) begin
            checks++;
            if (ack_exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected cyc=%0d: got ack=1, want ack=0", cyc);
            end else begin
                a = ack_exp_q.pop_front();
                if (a != cyc) begin
                    errors++;
                    $display("FAIL ack_timing: got ack at cyc %0d, want cyc %0d", cyc, a);
                end
            end
        end
        if (done && !drained) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: got no sample, want check at cyc %0d", e.name, e.cyc);
            end
            while (ack_exp_q.size() > 0) begin
                a = ack_exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL ack_missing: got no ack, want ack at cyc %0d", a);
            end
            drained = 1'b1;
        end
    end

    initial begin
        int e1, e2, e3;
        reset          = 1'b0;
        enable         = 1'b0;
        img_if.img_sel = 2'd0;
        img_if.img_req = 1'b0;

        // Reset state; release reset and raise enable together
        wait_to(2);
        expect_out("reset_state", 3'b000, 7'h00, 1'b0, 1'b0);
        reset  = 1'b1;
        enable = 1'b1;
        e1 = cyc;

        // Free-running scan with glyph 0
        wait_to(e1 + 2);  expect_out("blank_after_en", 3'b000, 7'h00, 1'b0, 1'b0);
        wait_to(e1 + 3);  expect_out("first_drive",    3'b100, G0C0,  1'b0, 1'b0);
        wait_to(e1 + 8);  expect_out("last_drive_c0",  3'b100, G0C0,  1'b0, 1'b0);
        wait_to(e1 + 9);  expect_out("blank_c1",       3'b000, 7'h00, 1'b0, 1'b0);
        wait_to(e1 + 11); expect_out("drive_c1",       3'b010, G0C1,  1'b0, 1'b0);
        wait_to(e1 + 19); expect_out("drive_c2",       3'b001, G0C2,  1'b0, 1'b0);
        wait_to(e1 + 24); expect_out("boundary",       3'b001, G0C2,  1'b0, 1'b0);
        wait_to(e1 + 25); expect_out("tick1",          3'b000, 7'h00, 1'b1, 1'b0);
        wait_to(e1 + 26); expect_out("tick1_end",      3'b000, 7'h00, 1'b0, 1'b0);

        // Glyph request mid-slot of index 1, applied at the boundary
        wait_to(e1 + 35);
        img_if.img_sel = 2'd2;
        img_if.img_req = 1'b1;
        ack_exp_q.push_back(e1 + 49);
        wait_to(e1 + 40); expect_out("no_midframe_c1", 3'b010, G0C1,  1'b0, 1'b0);
        wait_to(e1 + 43); expect_out("no_midframe_c2", 3'b001, G0C2,  1'b0, 1'b0);
        wait_to(e1 + 49); expect_out("ack_with_tick",  3'b000, 7'h00, 1'b1, 1'b1);
        img_if.img_req = 1'b0;
        wait_to(e1 + 51); expect_out("glyph2_c0",      3'b100, G2C0,  1'b0, 1'b0);

        // Disable during index 1 drive, then request while idle
        wait_to(e1 + 59); expect_out("drive_before_off", 3'b010, 7'h60, 1'b0, 1'b0);
        enable = 1'b0;
        wait_to(e1 + 60); expect_out("off_next_cycle", 3'b000, 7'h00, 1'b0, 1'b0);
        wait_to(e1 + 62);
        img_if.img_sel = 2'd1;
        img_if.img_req = 1'b1;
        ack_exp_q.push_back(e1 + 63);
        wait_to(e1 + 63); expect_out("idle_ack",       3'b000, 7'h00, 1'b0, 1'b1);
        img_if.img_req = 1'b0;
        wait_to(e1 + 66);
        enable = 1'b1;
        e2 = cyc;
        wait_to(e2 + 2);  expect_out("reen_blank",     3'b000, 7'h00, 1'b0, 1'b0);
        wait_to(e2 + 3);  expect_out("reen_glyph1_c0", 3'b100, G1C0,  1'b0, 1'b0);
        wait_to(e2 + 11); expect_out("reen_glyph1_c1", 3'b010, G1C1,  1'b0, 1'b0);

        // Asynchronous reset during drive
        wait_to(e2 + 12);
        reset = 1'b0;
        expect_out("async_reset",    3'b000, 7'h00, 1'b0, 1'b0);
        wait_to(e2 + 13);
        reset = 1'b1;
        e3 = cyc;
        wait_to(e3 + 3);  expect_out("post_reset_glyph0", 3'b100, G0C0, 1'b0, 1'b0);

        // img_sel changes while req held; req held past ack gives a second ack
        wait_to(e3 + 5);
        img_if.img_sel = 2'd1;
        img_if.img_req = 1'b1;
        ack_exp_q.push_back(e3 + 25);
        ack_exp_q.push_back(e3 + 49);
        wait_to(e3 + 10);
        img_if.img_sel = 2'd3;
        wait_to(e3 + 20); expect_out("held_req_c2",    3'b001, G0C2,  1'b0, 1'b0);
        wait_to(e3 + 25); expect_out("ack_sel3",       3'b000, 7'h00, 1'b1, 1'b1);
        wait_to(e3 + 27); expect_out("glyph3_c0",      3'b100, G3C0,  1'b0, 1'b0);
        wait_to(e3 + 49); expect_out("second_ack",     3'b000, 7'h00, 1'b1, 1'b1);
        wait_to(e3 + 55);
        img_if.img_req = 1'b0;
        wait_to(e3 + 80);

        done = 1'b1;
        repeat (3) @(posedge clock);
        if (!drained) begin
            $display("FAIL monitor_drain: got drained=0, want drained=1");
            $fatal(1, "monitor did not drain");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
